edge_frame_ctrl: RTL and testbench

Frame sequencer for the Sobel edge-detect datapath, between the CCD capture stage and the line-buffer/kernel stage. Tracks pixel coordinates and gates the line-buffer clock enable. Holds off kernel output while the line buffers prime. Latches the edge-mode switches only at frame start, so a frame is never processed with mixed modes. Flags malformed frames (short, long or truncated).

---
 rtl/edge_frame_ctrl_if.sv | 33 +++
 rtl/edge_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_edge_frame_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_frame_ctrl_if.sv
// Capture-side bus of the Sobel frame sequencer: frame/pixel valids, mode
// switches, and the coordinate/kernel/status outputs that go to the line buffers.
interface edge_frame_ctrl_if #(
    parameter int unsigned XW = 11,
    parameter int unsigned YW = 11
);
    logic          fval;
    logic          dval;
    logic          sw_edge;
    logic          sw_horiz;
    logic          lb_en_c;
    logic          px_val;
    logic [XW-1:0] x_cont;
    logic [YW-1:0] y_cont;
    logic          kernel_val;
    logic          is_edge_detect;
    logic          is_horizontal_edge;
    logic          frame_done;
    logic          err;
    logic [1:0]    state;

    modport master (
        output fval, dval, sw_edge, sw_horiz,
        input  lb_en_c, px_val, x_cont, y_cont, kernel_val,
               is_edge_detect, is_horizontal_edge, frame_done, err, state
    );

    modport slave (
        input  fval, dval, sw_edge, sw_horiz,
        output lb_en_c, px_val, x_cont, y_cont, kernel_val,
               is_edge_detect, is_horizontal_edge, frame_done, err, state
    );
endinterface

// File: rtl/edge_frame_ctrl.sv
// Frame sequencer for the Sobel edge datapath: pixel coordinates, line-buffer
// enable, priming hold-off, frame-stable mode latch and malformed-frame flag.
module edge_frame_ctrl #(
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned V_ACTIVE    = 960,
    parameter int unsigned PRIME_LINES = 2
) (
    input  logic             clk,
    input  logic             rst,
    edge_frame_ctrl_if.slave bus
);
    localparam int unsigned XW = 11;
    localparam int unsigned YW = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic          fval_d;
    logic          overrun;
    logic [1:0]    sw_edge_s;
    logic [1:0]    sw_horiz_s;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic          px_val;
    logic [XW-1:0] x_cont;
    logic [YW-1:0] y_cont;
    logic          kernel_val;
    logic          is_edge;
    logic          is_horiz;
    logic          frame_done;
    logic          err;

    logic in_frame_c;
    logic start_c;
    logic accept_c;
    logic x_wrap_c;
    logic y_last_c;

    assign in_frame_c = (state == PRIME) || (state == ACTIVE);
    assign start_c    = (state == IDLE) && bus.fval && !fval_d;
    assign accept_c   = bus.dval && bus.fval && in_frame_c && !overrun;
    assign x_wrap_c   = (x == XW'(H_ACTIVE - 1));
    assign y_last_c   = (y == YW'(V_ACTIVE - 1));

    assign bus.lb_en_c            = accept_c;
    assign bus.px_val             = px_val;
    assign bus.x_cont             = x_cont;
    assign bus.y_cont             = y_cont;
    assign bus.kernel_val         = kernel_val;
    assign bus.is_edge_detect     = is_edge;
    assign bus.is_horizontal_edge = is_horiz;
    assign bus.frame_done         = frame_done;
    assign bus.err                = err;
    assign bus.state              = state;

    // fval_d resets high so a frame already in flight at reset release is skipped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fval_d     <= 1'b1;
            overrun    <= 1'b0;
            sw_edge_s  <= 2'b00;
            sw_horiz_s <= 2'b00;
            x          <= '0;
            y          <= '0;
            px_val     <= 1'b0;
            x_cont     <= '0;
            y_cont     <= '0;
            kernel_val <= 1'b0;
            is_edge    <= 1'b0;
            is_horiz   <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            fval_d     <= bus.fval;
            sw_edge_s  <= {sw_edge_s[0], bus.sw_edge};
            sw_horiz_s <= {sw_horiz_s[0], bus.sw_horiz};
            px_val     <= accept_c;
            kernel_val <= accept_c && (x >= XW'(2)) && (y >= YW'(2));
            frame_done <= 1'b0;
            if (accept_c) begin
                x_cont <= x;
                y_cont <= y;
            end

            case (state)
                IDLE: begin
                    x       <= '0;
                    y       <= '0;
                    overrun <= 1'b0;
                    if (start_c) begin
                        state    <= PRIME;
                        err      <= 1'b0;
                        is_edge  <= sw_edge_s[1];
                        is_horiz <= sw_horiz_s[1];
                    end
                end
                PRIME, ACTIVE: begin
                    // A frame that ends before the last line wraps is truncated
                    if (!bus.fval) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        if (!overrun) err <= 1'b1;
                    end else begin
                        if (bus.dval && overrun) err <= 1'b1;
                        if (accept_c) begin
                            if (x_wrap_c) begin
                                x <= '0;
                                if (y_last_c) begin
                                    overrun <= 1'b1;
                                end else begin
                                    y <= y + YW'(1);
                                    if ((state == PRIME) && (y == YW'(PRIME_LINES - 1)))
                                        state <= ACTIVE;
                                end
                            end else begin
                                x <= x + XW'(1);
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_edge_frame_ctrl.sv
// Randomised-gap frame bench for edge_frame_ctrl on an 8x6 frame; expectations
// come from pixel-index arithmetic (column = k mod H, row = k div H).
module tb_edge_frame_ctrl;
    localparam int H    = 8;
    localparam int V    = 6;
    localparam int P    = 2;
    localparam int NPIX = H * V;

    logic clk = 1'b0;
    logic rst;

    edge_frame_ctrl_if bus ();

    edge_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .PRIME_LINES(P)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int px_x[$];
    int px_y[$];
    int px_k[$];
    int px_s[$];
    bit lb_q[$];
    bit err_q[$];
    int done_cnt = 0;
    bit rise_lb;
    bit fall_lb;

    // Output monitor: record every flagged pixel and frame-done pulse
    always @(posedge clk) begin
        #1;
        if (bus.px_val === 1'b1) begin
            px_x.push_back(int'(bus.x_cont));
            px_y.push_back(int'(bus.y_cont));
            px_k.push_back(int'(bus.kernel_val));
            px_s.push_back(int'(bus.state));
        end
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    task automatic clear_obs();
        px_x.delete(); px_y.delete(); px_k.delete(); px_s.delete();
        lb_q.delete(); err_q.delete();
        done_cnt = 0;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.dval = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_rise(input bit dv);
        @(negedge clk);
        bus.fval = 1'b1;
        bus.dval = dv;
        #1 rise_lb = bus.lb_en_c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.dval = 1'b0;
                @(posedge clk);
            end
            @(negedge clk);
            bus.dval = 1'b1;
            #1 lb_q.push_back(bus.lb_en_c);
            @(posedge clk);
            #1 err_q.push_back(bus.err);
        end
    endtask

    task automatic frame_fall(input bit dv);
        @(negedge clk);
        bus.fval = 1'b0;
        bus.dval = dv;
        #1 fall_lb = bus.lb_en_c;
        @(posedge clk);
        #1;
    endtask

    function automatic int count_lb();
        int c = 0;
        foreach (lb_q[i]) c += int'(lb_q[i]);
        return c;
    endfunction

    function automatic logic [31:0] all_outs();
        return {bus.lb_en_c, bus.px_val, bus.x_cont, bus.y_cont, bus.kernel_val,
                bus.is_edge_detect, bus.is_horizontal_edge, bus.frame_done, bus.err, bus.state};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.fval = 1'b0; bus.dval = 1'b0; bus.sw_edge = 1'b1; bus.sw_horiz = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (all_outs() !== 32'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        n_cmp++;
        if (bus.state !== 2'd0) begin
            n_bad++; $display("FAIL reset_idle_state: got %0d expected 0", bus.state);
        end
    endtask

    task automatic test_full_frame();
        bit ee;
        bit hh;
        int kcnt;
        int first_k;
        int n;
        ee = 1'($urandom_range(0, 1));
        hh = 1'($urandom_range(0, 1));
        bus.sw_edge = ee; bus.sw_horiz = hh;
        idle(4);
        clear_obs();
        frame_rise(1'b1);
        n_cmp++;
        if (rise_lb !== 1'b0) begin n_bad++; $display("FAIL full_rise_lb: got %0d expected 0", rise_lb); end
        n_cmp++;
        if (bus.state !== 2'd1) begin n_bad++; $display("FAIL full_prime: got %0d expected 1", bus.state); end
        n_cmp++;
        if (bus.is_edge_detect !== ee || bus.is_horizontal_edge !== hh) begin
            n_bad++; $display("FAIL full_modes: got %0d%0d expected %0d%0d",
                               bus.is_edge_detect, bus.is_horizontal_edge, ee, hh);
        end
        send_pixels(NPIX);
        frame_fall(1'b0);
        n_cmp++;
        if (bus.state !== 2'd3 || bus.frame_done !== 1'b1 || bus.err !== 1'b0) begin
            n_bad++; $display("FAIL full_done: got state=%0d done=%0d err=%0d expected 3 1 0",
                               bus.state, bus.frame_done, bus.err);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.state !== 2'd0 || bus.frame_done !== 1'b0) begin
            n_bad++; $display("FAIL full_back_idle: got state=%0d done=%0d expected 0 0",
                               bus.state, bus.frame_done);
        end
        idle(2);
        n_cmp++;
        if (count_lb() !== NPIX) begin n_bad++; $display("FAIL full_lb_count: got %0d expected %0d", count_lb(), NPIX); end
        n_cmp++;
        if (px_x.size() !== NPIX) begin n_bad++; $display("FAIL full_px_count: got %0d expected %0d", px_x.size(), NPIX); end
        n = (px_x.size() < NPIX) ? px_x.size() : NPIX;
        kcnt = 0;
        first_k = -1;
        for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (px_x[k] !== k % H || px_y[k] !== k / H) begin
                n_bad++; $display("FAIL full_coord[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                                   k, px_x[k], px_y[k], k % H, k / H);
            end
            n_cmp++;
            if (px_k[k] !== int'((k % H >= 2) && (k / H >= 2))) begin
                n_bad++; $display("FAIL full_kernel[%0d]: got %0d expected %0d",
                                   k, px_k[k], int'((k % H >= 2) && (k / H >= 2)));
            end
            n_cmp++;
            if (px_s[k] !== ((k >= P * H - 1) ? 2 : 1)) begin
                n_bad++; $display("FAIL full_state[%0d]: got %0d expected %0d",
                                   k, px_s[k], (k >= P * H - 1) ? 2 : 1);
            end
            kcnt += px_k[k];
            if (px_k[k] == 1 && first_k < 0) first_k = k;
        end
        n_cmp++;
        if (kcnt !== (H - 2) * (V - 2)) begin n_bad++; $display("FAIL full_kernel_count: got %0d expected %0d", kcnt, (H - 2) * (V - 2)); end
        n_cmp++;
        if (first_k < 0 || px_x[first_k] !== 2 || px_y[first_k] !== 2) begin
            n_bad++; $display("FAIL full_first_kernel: got index %0d expected (2,2)", first_k);
        end
        n_cmp++;
        if (done_cnt !== 1) begin n_bad++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_mode_latch();
        bit hh;
        hh = 1'($urandom_range(0, 1));
        bus.sw_edge = 1'b0; bus.sw_horiz = hh;
        idle(4);
        clear_obs();
        frame_rise(1'b0);
        n_cmp++;
        if (bus.is_edge_detect !== 1'b0) begin n_bad++; $display("FAIL mode_initial: got %0d expected 0", bus.is_edge_detect); end
        send_pixels(10);
        @(negedge clk);
        bus.sw_edge = 1'b1; bus.sw_horiz = ~hh;
        send_pixels(10);
        n_cmp++;
        if (bus.is_edge_detect !== 1'b0 || bus.is_horizontal_edge !== hh) begin
            n_bad++; $display("FAIL mode_mid_frame: got %0d%0d expected 0%0d",
                               bus.is_edge_detect, bus.is_horizontal_edge, hh);
        end
        send_pixels(NPIX - 20);
        frame_fall(1'b0);
        idle(3);
        n_cmp++;
        if (bus.is_edge_detect !== 1'b0) begin n_bad++; $display("FAIL mode_after_frame: got %0d expected 0", bus.is_edge_detect); end
        frame_rise(1'b0);
        n_cmp++;
        if (bus.is_edge_detect !== 1'b1 || bus.is_horizontal_edge !== ~hh) begin
            n_bad++; $display("FAIL mode_next_frame: got %0d%0d expected 1%0d",
                               bus.is_edge_detect, bus.is_horizontal_edge, ~hh);
        end
        send_pixels(NPIX);
        frame_fall(1'b0);
        idle(3);
    endtask

    task automatic test_overrun();
        idle(2);
        clear_obs();
        frame_rise(1'b0);
        send_pixels(NPIX + 2);
        frame_fall(1'b0);
        n_cmp++;
        if (bus.frame_done !== 1'b1 || bus.err !== 1'b1) begin
            n_bad++; $display("FAIL over_done: got done=%0d err=%0d expected 1 1", bus.frame_done, bus.err);
        end
        idle(3);
        n_cmp++;
        if (count_lb() !== NPIX) begin n_bad++; $display("FAIL over_lb_count: got %0d expected %0d", count_lb(), NPIX); end
        n_cmp++;
        if (lb_q[NPIX] !== 1'b0 || lb_q[NPIX + 1] !== 1'b0) begin
            n_bad++; $display("FAIL over_extra_lb: got %0d%0d expected 00", lb_q[NPIX], lb_q[NPIX + 1]);
        end
        n_cmp++;
        if (err_q[NPIX - 1] !== 1'b0 || err_q[NPIX] !== 1'b1) begin
            n_bad++; $display("FAIL over_err_timing: got %0d%0d expected 01", err_q[NPIX - 1], err_q[NPIX]);
        end
        n_cmp++;
        if (px_x.size() !== NPIX) begin n_bad++; $display("FAIL over_px_count: got %0d expected %0d", px_x.size(), NPIX); end
        n_cmp++;
        if (bus.x_cont !== 11'(H - 1) || bus.y_cont !== 11'(V - 1)) begin
            n_bad++; $display("FAIL over_hold_coord: got (%0d,%0d) expected (%0d,%0d)",
                               bus.x_cont, bus.y_cont, H - 1, V - 1);
        end
        n_cmp++;
        if (bus.err !== 1'b1) begin n_bad++; $display("FAIL over_err_sticky: got %0d expected 1", bus.err); end
        frame_rise(1'b0);
        n_cmp++;
        if (bus.err !== 1'b0) begin n_bad++; $display("FAIL over_err_clear: got %0d expected 0", bus.err); end
        send_pixels(NPIX);
        frame_fall(1'b0);
        idle(3);
    endtask

    task automatic test_truncated();
        clear_obs();
        frame_rise(1'b0);
        send_pixels(20);
        frame_fall(1'b1);
        n_cmp++;
        if (fall_lb !== 1'b0) begin n_bad++; $display("FAIL trunc_fall_lb: got %0d expected 0", fall_lb); end
        n_cmp++;
        if (bus.state !== 2'd3 || bus.frame_done !== 1'b1 || bus.err !== 1'b1) begin
            n_bad++; $display("FAIL trunc_done: got state=%0d done=%0d err=%0d expected 3 1 1",
                               bus.state, bus.frame_done, bus.err);
        end
        @(negedge clk);
        bus.dval = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.state !== 2'd0 || bus.frame_done !== 1'b0) begin
            n_bad++; $display("FAIL trunc_idle: got state=%0d done=%0d expected 0 0", bus.state, bus.frame_done);
        end
        idle(3);
        n_cmp++;
        if (px_x.size() !== 20 || done_cnt !== 1) begin
            n_bad++; $display("FAIL trunc_counts: got px=%0d done=%0d expected 20 1", px_x.size(), done_cnt);
        end
    endtask

    task automatic test_fval_high_at_reset();
        rst = 1'b1;
        @(negedge clk);
        bus.fval = 1'b1; bus.dval = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_obs();
        send_pixels(30);
        n_cmp++;
        if (count_lb() !== 0 || px_x.size() !== 0) begin
            n_bad++; $display("FAIL midrst_lb: got lb=%0d px=%0d expected 0 0", count_lb(), px_x.size());
        end
        frame_fall(1'b0);
        n_cmp++;
        if (bus.state !== 2'd0 || bus.frame_done !== 1'b0) begin
            n_bad++; $display("FAIL midrst_no_done: got state=%0d done=%0d expected 0 0", bus.state, bus.frame_done);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_frame();
        bus.sw_edge = 1'b1; bus.sw_horiz = 1'b1;
        idle(4);
        clear_obs();
        frame_rise(1'b0);
        n_cmp++;
        if (bus.is_edge_detect !== 1'b1) begin n_bad++; $display("FAIL arst_pre_mode: got %0d expected 1", bus.is_edge_detect); end
        send_pixels(3 * H + 3);
        @(negedge clk);
        bus.dval = 1'b1;
        #1;
        n_cmp++;
        if (bus.lb_en_c !== 1'b1) begin n_bad++; $display("FAIL arst_pre_lb: got %0d expected 1", bus.lb_en_c); end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (all_outs() !== 32'd0) begin n_bad++; $display("FAIL arst_outputs: got %h expected 0", all_outs()); end
        @(negedge clk);
        rst = 1'b0;
        bus.dval = 1'b0;
        frame_fall(1'b0);
        n_cmp++;
        if (bus.state !== 2'd0) begin n_bad++; $display("FAIL arst_no_done: got %0d expected 0", bus.state); end
        idle(3);
        clear_obs();
        frame_rise(1'b0);
        send_pixels(NPIX);
        frame_fall(1'b0);
        idle(3);
        n_cmp++;
        if (px_x.size() !== NPIX || done_cnt !== 1) begin
            n_bad++; $display("FAIL arst_next_counts: got px=%0d done=%0d expected %0d 1", px_x.size(), done_cnt, NPIX);
        end
        n_cmp++;
        if (px_x.size() == 0 || px_x[0] !== 0 || px_y[0] !== 0) begin
            n_bad++; $display("FAIL arst_next_origin: got first pixel count=%0d expected (0,0)", px_x.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.fval = 1'b0; bus.dval = 1'b0; bus.sw_edge = 1'b0; bus.sw_horiz = 1'b0;
        test_reset();
        test_full_frame();
        test_mode_latch();
        test_overrun();
        test_truncated();
        test_fval_high_at_reset();
        test_full_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
